// File: rtl/cache_line_ctrl.sv
// Refill / invalidate sequencer for one cache set array; sole writer of the tag, valid and data BRAM A-ports.
// Optional feature: define CACHE_INIT_SWEEP_EN to clear every valid bit after reset before serving requests.
module cache_line_ctrl #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20,
    parameter int WORDS   = 4,
    parameter int WAYS    = 2,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [INDEX_W-1:0]      miss_index,
    input  logic [TAG_W-1:0]        miss_tag,
    input  logic [WAY_W-1:0]        miss_way,
    output logic                    miss_ack,
    input  logic                    inv_req,
    input  logic [INDEX_W-1:0]      inv_index,
    input  logic [WAY_W-1:0]        inv_way,
    output logic                    inv_ack,
    output logic                    busy,
    output logic                    rd_req,
    output logic [31:0]             rd_addr,
    input  logic                    rd_gnt,
    input  logic                    rd_valid,
    input  logic [31:0]             rd_data,
    input  logic                    rd_last,
    output logic [INDEX_W-1:0]      bram_addr,
    output logic [WAYS-1:0]         tag_we,
    output logic [TAG_W-1:0]        tag_din,
    output logic [WAYS-1:0]         vl_we,
    output logic                    vl_din,
    output logic [WAYS*WORDS*4-1:0] data_we,
    output logic [31:0]             data_din
);

    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PAD_W  = 32 - TAG_W - INDEX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [2:0] {
        ST_SWEEP,
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_COMMIT,
        ST_INV
    } state_t;

`ifdef CACHE_INIT_SWEEP_EN
    localparam state_t RESET_STATE = ST_SWEEP;
    localparam logic [INDEX_W-1:0] SWEEP_ONE = INDEX_W'(1);
    logic [INDEX_W-1:0] sweep_q, sweep_d;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            index_q <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            beat_q  <= '0;
`ifdef CACHE_INIT_SWEEP_EN
            sweep_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            way_q   <= way_d;
            beat_q  <= beat_d;
`ifdef CACHE_INIT_SWEEP_EN
            sweep_q <= sweep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        tag_d     = tag_q;
        way_d     = way_q;
        beat_d    = beat_q;
`ifdef CACHE_INIT_SWEEP_EN
        sweep_d   = sweep_q;
`endif
        miss_ack  = 1'b0;
        inv_ack   = 1'b0;
        busy      = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        bram_addr = '0;
        tag_we    = '0;
        tag_din   = '0;
        vl_we     = '0;
        vl_din    = 1'b0;
        data_we   = '0;
        data_din  = '0;

        // Outputs are forced quiet while rst is high so an aborted refill cannot write another beat.
        if (!rst) begin
            case (state_q)
`ifdef CACHE_INIT_SWEEP_EN
                ST_SWEEP: begin
                    busy      = 1'b1;
                    bram_addr = sweep_q;
                    vl_we     = '1;
                    vl_din    = 1'b0;
                    sweep_d   = sweep_q + SWEEP_ONE;
                    if (sweep_q == '1) begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    if (miss_req) begin
                        index_d = miss_index;
                        tag_d   = miss_tag;
                        way_d   = miss_way;
                        state_d = ST_REQ;
                    end else if (inv_req) begin
                        state_d = ST_INV;
                    end
                end
                ST_REQ: begin
                    busy      = 1'b1;
                    rd_req    = 1'b1;
                    rd_addr   = {tag_q, index_q, {PAD_W{1'b0}}};
                    bram_addr = index_q;
                    if (rd_gnt) begin
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    busy      = 1'b1;
                    bram_addr = index_q;
                    if (rd_valid) begin
                        data_we[(int'(way_q) * WORDS + int'(beat_q)) * 4 +: 4] = 4'hF;
                        data_din = rd_data;
                        beat_d   = beat_q + BEAT_ONE;
                        // Leaving FILL on the last word means surplus beats are never written.
                        if (rd_last || (beat_q == LAST_BEAT)) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    busy          = 1'b1;
                    bram_addr     = index_q;
                    tag_we[way_q] = 1'b1;
                    tag_din       = tag_q;
                    vl_we[way_q]  = 1'b1;
                    vl_din        = 1'b1;
                    miss_ack      = 1'b1;
                    state_d       = ST_IDLE;
                end
                ST_INV: begin
                    busy           = 1'b1;
                    bram_addr      = inv_index;
                    vl_we[inv_way] = 1'b1;
                    vl_din         = 1'b0;
                    inv_ack        = 1'b1;
                    state_d        = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench for cache_line_ctrl: expected BRAM write events are queued by the scenario tasks
// and matched by a monitor that decodes the BRAM ports every cycle.
module tb_cache_line_ctrl;

    localparam int INDEX_W = 7;
    localparam int TAG_W   = 20;
    localparam int WORDS   = 4;
    localparam int WAYS    = 2;

    localparam int K_DATA   = 0;
    localparam int K_COMMIT = 1;
    localparam int K_INV    = 2;
    localparam int K_SWEEP  = 3;
    localparam int K_BAD    = 9;

    typedef struct {
        int          kind;
        int          addr;
        int          way;
        int          word;
        logic [31:0] val;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    miss_req = 1'b0;
    logic [INDEX_W-1:0]      miss_index = '0;
    logic [TAG_W-1:0]        miss_tag = '0;
    logic [0:0]              miss_way = '0;
    logic                    miss_ack;
    logic                    inv_req = 1'b0;
    logic [INDEX_W-1:0]      inv_index = '0;
    logic [0:0]              inv_way = '0;
    logic                    inv_ack;
    logic                    busy;
    logic                    rd_req;
    logic [31:0]             rd_addr;
    logic                    rd_gnt = 1'b0;
    logic                    rd_valid = 1'b0;
    logic [31:0]             rd_data = '0;
    logic                    rd_last = 1'b0;
    logic [INDEX_W-1:0]      bram_addr;
    logic [WAYS-1:0]         tag_we;
    logic [TAG_W-1:0]        tag_din;
    logic [WAYS-1:0]         vl_we;
    logic                    vl_din;
    logic [WAYS*WORDS*4-1:0] data_we;
    logic [31:0]             data_din;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    cache_line_ctrl #(
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W),
        .WORDS  (WORDS),
        .WAYS   (WAYS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .miss_req  (miss_req),
        .miss_index(miss_index),
        .miss_tag  (miss_tag),
        .miss_way  (miss_way),
        .miss_ack  (miss_ack),
        .inv_req   (inv_req),
        .inv_index (inv_index),
        .inv_way   (inv_way),
        .inv_ack   (inv_ack),
        .busy      (busy),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .bram_addr (bram_addr),
        .tag_we    (tag_we),
        .tag_din   (tag_din),
        .vl_we     (vl_we),
        .vl_din    (vl_din),
        .data_we   (data_we),
        .data_din  (data_din)
    );

    // Monitor: decode each cycle's BRAM activity into one event and match it against the queue.
    always @(negedge clk) begin
        ev_t        ev;
        ev_t        e;
        int         nz;
        bit         bad;
        bit         have;
        logic [3:0] g;
        ev   = '{kind: K_BAD, addr: int'(bram_addr), way: 0, word: 0, val: 32'h0};
        nz   = 0;
        bad  = 1'b0;
        have = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            for (int w = 0; w < WORDS; w++) begin
                g = data_we[(k*WORDS+w)*4 +: 4];
                if (g != 4'h0) begin
                    nz++;
                    if (g !== 4'hF) bad = 1'b1;
                    ev.way  = k;
                    ev.word = w;
                end
            end
        end
        if (nz > 0) begin
            have   = 1'b1;
            ev.val = data_din;
            if (nz == 1 && !bad && tag_we == 0 && vl_we == 0 && !miss_ack && !inv_ack)
                ev.kind = K_DATA;
        end else if (tag_we != 0 || vl_we != 0 || miss_ack || inv_ack) begin
            have = 1'b1;
            for (int k = 0; k < WAYS; k++) begin
                if (vl_we[k]) ev.way = k;
            end
            if ($onehot(tag_we) && vl_we == tag_we && vl_din === 1'b1 && miss_ack && !inv_ack) begin
                ev.kind = K_COMMIT;
                ev.val  = 32'(tag_din);
            end else if (tag_we == 0 && vl_we == '1 && vl_din === 1'b0 && !miss_ack && !inv_ack) begin
                ev.kind = K_SWEEP;
                ev.way  = 0;
            end else if (tag_we == 0 && $onehot(vl_we) && vl_din === 1'b0 && inv_ack && !miss_ack) begin
                ev.kind = K_INV;
            end
        end
        if (have) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got kind=%0d addr=%0d way=%0d word=%0d val=%h, required no BRAM activity",
                         ev.kind, ev.addr, ev.way, ev.word, ev.val);
            end else begin
                e = exp_q.pop_front();
                if (ev.kind !== e.kind || ev.addr !== e.addr || ev.way !== e.way ||
                    ev.word !== e.word || ev.val !== e.val) begin
                    errors++;
                    $display("FAIL sb_event: got kind=%0d addr=%0d way=%0d word=%0d val=%h, required kind=%0d addr=%0d way=%0d word=%0d val=%h",
                             ev.kind, ev.addr, ev.way, ev.word, ev.val, e.kind, e.addr, e.way, e.word, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d expected writes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at posedge+1 right after the reset edge; leaves the bench at posedge+1 in IDLE.
    task automatic settle_after_reset(input string name);
`ifdef CACHE_INIT_SWEEP_EN
        int n;
        for (int i = 0; i < 128; i++) exp_q.push_back('{kind: K_SWEEP, addr: i, way: 0, word: 0, val: 32'h0});
`endif
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0 || miss_ack !== 1'b0 || inv_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_reset: got rd_req=%b miss_ack=%b inv_ack=%b, required 0 0 0", name, rd_req, miss_ack, inv_ack);
        end
`ifdef CACHE_INIT_SWEEP_EN
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL %s_sweep_len: got %0d busy cycles, required 128", name, n);
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b, required 0", name, busy);
        end
`endif
        tick();
    endtask

    // Full refill: vpat bit i = rd_valid in FILL cycle i; last_at = accepted beat that carries rd_last (-1 none).
    task automatic run_miss(input int idx, input int tag, input int way, input int gnt_wait,
                            input int vpat, input int plen, input int last_at,
                            input logic [31:0] dbase, input string name);
        int          acc;
        int          b;
        int          final_i;
        int          ack_i;
        bit          done;
        logic [31:0] exp_addr;
        acc = 0; b = 0; final_i = -1; ack_i = -1; done = 1'b0;
        exp_addr = (32'(tag) << 12) | (32'(idx) << 5);
        for (int i = 0; i < plen; i++) begin
            if (vpat[i] && !done) begin
                exp_q.push_back('{kind: K_DATA, addr: idx, way: way, word: acc, val: dbase + 32'(acc) * 32'h11});
                if (acc == last_at || acc == WORDS - 1) begin
                    done    = 1'b1;
                    final_i = i;
                end
                acc++;
            end
        end
        exp_q.push_back('{kind: K_COMMIT, addr: idx, way: way, word: 0, val: 32'(tag)});

        miss_req   = 1'b1;
        miss_index = idx[INDEX_W-1:0];
        miss_tag   = tag[TAG_W-1:0];
        miss_way   = way[0:0];
        tick();
        for (int i = 0; i < gnt_wait; i++) begin
            @(negedge clk);
            checks++;
            if (rd_req !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_req_wait: got rd_req=%b busy=%b, required 1 1", name, rd_req, busy);
            end
            tick();
        end
        rd_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_rd_addr: got rd_req=%b rd_addr=%h, required 1 %h", name, rd_req, rd_addr, exp_addr);
        end
        tick();
        rd_gnt = 1'b0;

        for (int i = 0; i < plen + 20; i++) begin
            if (i < plen && vpat[i]) begin
                rd_valid = 1'b1;
                rd_data  = dbase + 32'(b) * 32'h11;
                rd_last  = (b == last_at);
                b++;
            end else begin
                rd_valid = 1'b0;
                rd_data  = '0;
                rd_last  = 1'b0;
            end
            @(negedge clk);
            if (miss_ack === 1'b1 && ack_i < 0) begin
                ack_i    = i;
                miss_req = 1'b0;
            end
            tick();
            if (ack_i >= 0 && i >= plen - 1) break;
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        miss_req = 1'b0;
        checks++;
        if (ack_i !== final_i + 1) begin
            errors++;
            $display("FAIL %s_ack_cycle: got miss_ack in fill cycle %0d, required %0d", name, ack_i, final_i + 1);
        end
        check_queue_empty(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({busy, rd_req, miss_ack, inv_ack, vl_din} !== 5'b0 || rd_addr !== 32'h0 || bram_addr !== '0 ||
            tag_we !== '0 || tag_din !== '0 || vl_we !== '0 || data_we !== '0 || data_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b rd_req=%b rd_addr=%h bram_addr=%h tag_we=%b vl_we=%b data_we=%h, required all zero",
                     busy, rd_req, rd_addr, bram_addr, tag_we, vl_we, data_we);
        end
        tick();
        rst = 1'b0;
        settle_after_reset("reset");
        check_queue_empty("reset");
        $display("test_reset done");
    endtask

    task automatic test_refill();
        run_miss(5, 'hABCDE, 1, 2, 'hF, 4, -1, 32'h11, "refill");
        $display("test_refill done: idx=5 tag=abcde way=1");
    endtask

    task automatic test_gapped_beats();
        run_miss(6, 'h00F0F, 0, 1, 'h59, 7, -1, 32'h100, "gapped");
        $display("test_gapped_beats done: idx=6 way=0");
    endtask

    task automatic test_early_last();
        run_miss(127, 'hFFFFF, 1, 0, 'hF, 4, 1, 32'h2000, "early_last");
        $display("test_early_last done: idx=127 way=1");
    endtask

    task automatic test_overflow();
        run_miss(0, 'h13579, 0, 3, 'h3F, 6, -1, 32'h3000, "overflow");
        $display("test_overflow done: idx=0 way=0");
    endtask

    task automatic test_miss_inv_collision();
        inv_req   = 1'b1;
        inv_index = 7'd9;
        inv_way   = 1'b0;
        run_miss(3, 'h12345, 1, 0, 'hF, 4, -1, 32'h4000, "collide");
        exp_q.push_back('{kind: K_INV, addr: 9, way: 0, word: 0, val: 32'h0});
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || inv_ack !== 1'b0) begin
            errors++;
            $display("FAIL collide_idle_gap: got busy=%b inv_ack=%b, required 0 0", busy, inv_ack);
        end
        tick();
        @(negedge clk);
        checks++;
        if (inv_ack !== 1'b1 || bram_addr !== 7'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_inv: got inv_ack=%b bram_addr=%0d busy=%b, required 1 9 1", inv_ack, bram_addr, busy);
        end
        inv_req = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (inv_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL collide_inv_pulse: got inv_ack=%b busy=%b, required 0 0", inv_ack, busy);
        end
        tick();
        check_queue_empty("collide");
        $display("test_miss_inv_collision done: inv idx=9 way=0");
    endtask

    task automatic test_reset_mid_fill();
        miss_req   = 1'b1;
        miss_index = 7'd20;
        miss_tag   = 20'h55555;
        miss_way   = 1'b0;
        exp_q.push_back('{kind: K_DATA, addr: 20, way: 0, word: 0, val: 32'h5000});
        exp_q.push_back('{kind: K_DATA, addr: 20, way: 0, word: 1, val: 32'h5011});
        tick();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_valid = 1'b1;
            rd_data  = 32'h5000 + 32'(i) * 32'h11;
            tick();
        end
        rd_data = 32'h5022;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if (data_we !== '0 || tag_we !== '0 || vl_we !== '0 || miss_ack !== 1'b0) begin
            errors++;
            $display("FAIL midfill_abort: got data_we=%h tag_we=%b vl_we=%b miss_ack=%b, required 0 0 0 0",
                     data_we, tag_we, vl_we, miss_ack);
        end
        tick();
        rst      = 1'b0;
        miss_req = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        settle_after_reset("midfill");
        check_queue_empty("midfill");
        $display("test_reset_mid_fill done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_refill();
        test_gapped_beats();
        test_early_last();
        test_overflow();
        test_miss_inv_collision();
        test_reset_mid_fill();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
